// File: rtl/hf_mod_detect_ssp.sv
// ISO14443 reader-side receive path: edge filter on the ADC stream, per-window
// load-modulation decision, and SSP serialisation of decisions with a per-frame 1-bit count.
module hf_mod_detect_ssp #(
    parameter int ADC_W       = 8,
    parameter int SUB_LOG2    = 4,
    parameter int FRAME_LOG2  = 3,
    parameter int RESET_PHASE = 3
) (
    input  logic                  osc_clk,
    input  logic                  nrst,
    input  logic [ADC_W-1:0]      adc_d,
    input  logic [ADC_W-1:0]      threshold,
    input  logic                  listen,
    input  logic                  resync,
    output logic                  curbit,
    output logic                  ssp_clk,
    output logic                  ssp_frame,
    output logic                  ssp_din,
    output logic [FRAME_LOG2:0]   mod_count,
    output logic                  frame_done
);

    localparam int CW = SUB_LOG2 + FRAME_LOG2;
    localparam int FW = ADC_W + 3;
    localparam int AW = FRAME_LOG2 + 1;

    localparam logic [SUB_LOG2-1:0] WIN_ZERO   = '0;
    localparam logic [SUB_LOG2-1:0] WIN_DECIDE = SUB_LOG2'(RESET_PHASE);
    localparam logic [SUB_LOG2-1:0] WIN_HALF   = SUB_LOG2'(2 ** (SUB_LOG2 - 1));
    localparam logic [CW-1:0]       FRAME_SET  = CW'(2 ** (SUB_LOG2 - 1) - 1);
    localparam logic [CW-1:0]       FRAME_CLR  = CW'(2 ** SUB_LOG2 + 2 ** (SUB_LOG2 - 1) - 1);
    localparam logic [FRAME_LOG2-1:0] BIT_FIRST = '0;
    localparam logic signed [FW-1:0]  ZERO_F    = '0;

    logic [CW-1:0]          cnt_r;
    logic [ADC_W-1:0]       p1_r, p2_r, p3_r, p4_r;
    logic signed [FW-1:0]   fall_max_r, rise_min_r;
    logic [AW-1:0]          acc_r;
    logic                   curbit_r, ssp_clk_r, ssp_frame_r, ssp_din_r, frame_done_r;
    logic [AW-1:0]          mod_count_r;

    logic [SUB_LOG2-1:0]    win_s;
    logic [FRAME_LOG2-1:0]  bitidx_s;
    logic signed [FW-1:0]   f_s, thr_s, neg_thr_s;
    logic                   bit_s;

    // Window phase, bit index, filter output and the bit about to be sent.
    always_comb begin
        win_s     = cnt_r[SUB_LOG2-1:0];
        bitidx_s  = cnt_r[CW-1:SUB_LOG2];
        // Zero-extended operands: three headroom bits make wrap-around impossible.
        f_s       = ({2'b00, p4_r, 1'b0} + {3'b000, p3_r}) - ({2'b00, adc_d, 1'b0} + {3'b000, p1_r});
        thr_s     = {3'b000, threshold};
        neg_thr_s = -thr_s;
        bit_s     = listen & curbit_r;
    end

    // Phase counter; resync restarts it so the next edge is a bit boundary.
    always_ff @(posedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r <= '0;
        end else if (resync) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // ADC delay line feeding the edge filter.
    always_ff @(posedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            p1_r <= '0;
            p2_r <= '0;
            p3_r <= '0;
            p4_r <= '0;
        end else begin
            p1_r <= adc_d;
            p2_r <= p1_r;
            p3_r <= p2_r;
            p4_r <= p3_r;
        end
    end

    // Edge trackers and the per-window decision.
    always_ff @(posedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            fall_max_r <= ZERO_F;
            rise_min_r <= ZERO_F;
            curbit_r   <= 1'b0;
        end else if (win_s == WIN_DECIDE) begin
            curbit_r   <= listen & (fall_max_r > thr_s) & (rise_min_r < neg_thr_s);
            fall_max_r <= ZERO_F;
            rise_min_r <= ZERO_F;
        end else if (!listen) begin
            fall_max_r <= ZERO_F;
            rise_min_r <= ZERO_F;
        end else if ((f_s > ZERO_F) && (f_s > fall_max_r)) begin
            fall_max_r <= f_s;
        end else if (f_s < rise_min_r) begin
            rise_min_r <= f_s;
        end
    end

    // Serial bit stage and per-frame modulation count.
    always_ff @(posedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            ssp_din_r    <= 1'b0;
            acc_r        <= '0;
            mod_count_r  <= '0;
            frame_done_r <= 1'b0;
        end else if (win_s == WIN_ZERO) begin
            ssp_din_r <= bit_s;
            if (bitidx_s == BIT_FIRST) begin
                acc_r        <= {{(AW-1){1'b0}}, bit_s};
                mod_count_r  <= acc_r;
                frame_done_r <= 1'b1;
            end else begin
                acc_r        <= acc_r + {{(AW-1){1'b0}}, bit_s};
                frame_done_r <= 1'b0;
            end
        end else begin
            frame_done_r <= 1'b0;
        end
    end

    // SSP clock and frame strobes derived from the phase counter.
    always_ff @(posedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            ssp_clk_r   <= 1'b0;
            ssp_frame_r <= 1'b0;
        end else begin
            if (win_s == WIN_ZERO) begin
                ssp_clk_r <= 1'b1;
            end else if (win_s == WIN_HALF) begin
                ssp_clk_r <= 1'b0;
            end
            if (cnt_r == FRAME_SET) begin
                ssp_frame_r <= 1'b1;
            end else if (cnt_r == FRAME_CLR) begin
                ssp_frame_r <= 1'b0;
            end
        end
    end

    assign curbit     = curbit_r;
    assign ssp_clk    = ssp_clk_r;
    assign ssp_frame  = ssp_frame_r;
    assign ssp_din    = ssp_din_r;
    assign mod_count  = mod_count_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_hf_mod_detect_ssp.sv
// Directed bench for hf_mod_detect_ssp: default instance plus a SUB_LOG2=3/FRAME_LOG2=4 instance.
module tb_hf_mod_detect_ssp;

    logic       clk = 1'b0;
    logic       nrst, listen, resync, resync2;
    logic [7:0] adc_d, threshold;

    logic       curbit, ssp_clk, ssp_frame, ssp_din, frame_done;
    logic [3:0] mod_count;
    logic       curbit2, ssp_clk2, ssp_frame2, ssp_din2, frame_done2;
    logic [4:0] mod_count2;

    int vectors = 0;
    int miscompares = 0;
    int cnt_m = 0, cnt2_m = 0, last_c = 0, last_c2 = 0;

    hf_mod_detect_ssp dut (
        .osc_clk(clk), .nrst(nrst), .adc_d(adc_d), .threshold(threshold),
        .listen(listen), .resync(resync), .curbit(curbit), .ssp_clk(ssp_clk),
        .ssp_frame(ssp_frame), .ssp_din(ssp_din), .mod_count(mod_count),
        .frame_done(frame_done)
    );

    hf_mod_detect_ssp #(.ADC_W(8), .SUB_LOG2(3), .FRAME_LOG2(4), .RESET_PHASE(3)) dut2 (
        .osc_clk(clk), .nrst(nrst), .adc_d(adc_d), .threshold(threshold),
        .listen(listen), .resync(resync2), .curbit(curbit2), .ssp_clk(ssp_clk2),
        .ssp_frame(ssp_frame2), .ssp_din(ssp_din2), .mod_count(mod_count2),
        .frame_done(frame_done2)
    );

    always #5 clk = ~clk;

    // One clock edge; last_c/last_c2 hold the counter value the edge acted on.
    task automatic tick();
        @(posedge clk);
        #1;
        last_c  = cnt_m;
        last_c2 = cnt2_m;
        if (nrst) begin
            cnt_m  = (cnt_m + 1) % 128;
            cnt2_m = resync2 ? 0 : (cnt2_m + 1) % 128;
        end
    endtask

    task automatic step(input logic [7:0] a);
        adc_d = a;
        tick();
    endtask

    task automatic align();
        while (cnt_m != 0) step(adc_d);
    endtask

    function automatic logic [7:0] sq(input int k);
        return (((k / 8) % 2) == 1) ? 8'd200 : 8'd100;
    endfunction

    task automatic test_reset();
        logic [8:0] got, exp;
        nrst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            adc_d = 8'($urandom);
            threshold = 8'($urandom);
            listen = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            vectors++;
            if ({curbit, ssp_clk, ssp_frame, ssp_din, mod_count, frame_done} !== 9'd0 ||
                {curbit2, ssp_clk2, ssp_frame2, ssp_din2, mod_count2, frame_done2} !== 10'd0) begin
                miscompares++;
                $display("FAIL reset_hold: got %b / %b want all zero",
                         {curbit, ssp_clk, ssp_frame, ssp_din, mod_count, frame_done},
                         {curbit2, ssp_clk2, ssp_frame2, ssp_din2, mod_count2, frame_done2});
            end
        end
        listen = 1'b0;
        threshold = 8'd40;
        adc_d = 8'd128;
        cnt_m = 0;
        cnt2_m = 0;
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 130; k++) begin
            step(8'd128);
            got = {curbit, ssp_clk, ssp_frame, ssp_din, mod_count, frame_done};
            exp = {1'b0, ((last_c % 16) < 8), (last_c >= 7 && last_c < 23), 1'b0, 4'd0, (last_c == 0)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_run cnt=%0d: got %b want %b", last_c, got, exp);
            end
        end
    endtask

    task automatic test_square();
        threshold = 8'd40;
        listen = 1'b1;
        align();
        for (int k = 0; k <= 384; k++) begin
            step(sq(k));
            vectors++;
            if (frame_done !== (k % 128 == 0)) begin
                miscompares++;
                $display("FAIL sq_frame_done k=%0d: got %b want %b", k, frame_done, (k % 128 == 0));
            end
            if (k >= 128 && k % 16 == 0) begin
                vectors++;
                if (ssp_din !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sq_din k=%0d: got %b want 1", k, ssp_din);
                end
            end
            if (k >= 128 && k % 16 == 3) begin
                vectors++;
                if (curbit !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sq_curbit k=%0d: got %b want 1", k, curbit);
                end
            end
            if (k == 256 || k == 384) begin
                vectors++;
                if ({frame_done, mod_count} !== {1'b1, 4'd8}) begin
                    miscompares++;
                    $display("FAIL sq_mod_count k=%0d: got %0d (done %b) want 8", k, mod_count, frame_done);
                end
            end
        end
    endtask

    task automatic test_constant();
        threshold = 8'd40;
        listen = 1'b1;
        align();
        for (int k = 0; k <= 256; k++) begin
            step(8'd128);
            if (k >= 128 && k % 16 == 0) begin
                vectors++;
                if (ssp_din !== 1'b0) begin
                    miscompares++;
                    $display("FAIL const_din k=%0d: got %b want 0", k, ssp_din);
                end
            end
            if (k >= 128 && k % 16 == 3) begin
                vectors++;
                if (curbit !== 1'b0) begin
                    miscompares++;
                    $display("FAIL const_curbit k=%0d: got %b want 0", k, curbit);
                end
            end
            if (k == 256) begin
                vectors++;
                if ({frame_done, mod_count} !== {1'b1, 4'd0}) begin
                    miscompares++;
                    $display("FAIL const_mod_count: got %0d (done %b) want 0", mod_count, frame_done);
                end
            end
        end
    endtask

    // A +20 impulse yields f = -40,-20,0,20,40: fall_max 40, rise_min -40.
    task automatic test_threshold();
        listen = 1'b1;
        threshold = 8'd40;
        align();
        for (int k = 0; k <= 96; k++) begin
            threshold = (k >= 36 && k < 67) ? 8'd39 : 8'd40;
            step((k == 20 || k == 36 || k == 52) ? 8'd148 : 8'd128);
            if (k == 35 || k == 51 || k == 67 || k == 83) begin
                vectors++;
                if (curbit !== (k == 51)) begin
                    miscompares++;
                    $display("FAIL thr_curbit k=%0d: got %b want %b", k, curbit, (k == 51));
                end
            end
            if (k == 48 || k == 64 || k == 80) begin
                vectors++;
                if (ssp_din !== (k == 64)) begin
                    miscompares++;
                    $display("FAIL thr_din k=%0d: got %b want %b", k, ssp_din, (k == 64));
                end
            end
        end
        threshold = 8'd40;
    endtask

    task automatic test_listen();
        threshold = 8'd40;
        listen = 1'b1;
        align();
        for (int k = 0; k <= 256; k++) begin
            listen = (k < 184);
            step(sq(k));
            if (k >= 128 && k < 256 && k % 16 == 0) begin
                vectors++;
                if (ssp_din !== (k < 192)) begin
                    miscompares++;
                    $display("FAIL listen_din k=%0d: got %b want %b", k, ssp_din, (k < 192));
                end
            end
            if (k == 179 || k == 195) begin
                vectors++;
                if (curbit !== (k == 179)) begin
                    miscompares++;
                    $display("FAIL listen_curbit k=%0d: got %b want %b", k, curbit, (k == 179));
                end
            end
            if (k == 256) begin
                vectors++;
                if ({frame_done, mod_count} !== {1'b1, 4'd4}) begin
                    miscompares++;
                    $display("FAIL listen_mod_count: got %0d (done %b) want 4", mod_count, frame_done);
                end
            end
        end
        listen = 1'b1;
    endtask

    task automatic test_param();
        logic [2:0] got, exp;
        align();
        for (int k = 0; k < 200; k++) begin
            resync2 = (k == 50);
            step(8'd128);
            got = {ssp_clk2, ssp_frame2, frame_done2};
            exp = {((last_c2 % 8) < 4), (last_c2 >= 3 && last_c2 < 11), (last_c2 == 0)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL param k=%0d cnt=%0d: got %b want %b", k, last_c2, got, exp);
            end
            if (k == 51) begin
                vectors++;
                if (frame_done2 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL param_resync_done: got %b want 1", frame_done2);
                end
            end
        end
        resync2 = 1'b0;
    endtask

    task automatic test_async_reset();
        listen = 1'b1;
        threshold = 8'd40;
        align();
        for (int k = 0; k <= 128; k++) step(sq(k));
        vectors++;
        if ({ssp_clk, ssp_din, frame_done} !== 3'b111) begin
            miscompares++;
            $display("FAIL pre_reset: got %b want 111", {ssp_clk, ssp_din, frame_done});
        end
        #2;
        nrst = 1'b0;
        #1;
        vectors++;
        if ({curbit, ssp_clk, ssp_frame, ssp_din, mod_count, frame_done} !== 9'd0 ||
            {curbit2, ssp_clk2, ssp_frame2, ssp_din2, mod_count2, frame_done2} !== 10'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %b / %b want all zero",
                     {curbit, ssp_clk, ssp_frame, ssp_din, mod_count, frame_done},
                     {curbit2, ssp_clk2, ssp_frame2, ssp_din2, mod_count2, frame_done2});
        end
        @(negedge clk);
        cnt_m = 0;
        cnt2_m = 0;
        nrst = 1'b1;
        for (int k = 0; k < 24; k++) begin
            step(8'd128);
            vectors++;
            if ({ssp_clk, ssp_frame, frame_done, mod_count} !==
                {((k % 16) < 8), (k >= 7 && k < 23), (k == 0), 4'd0}) begin
                miscompares++;
                $display("FAIL post_reset k=%0d: got %b%b%b %0d", k, ssp_clk, ssp_frame, frame_done, mod_count);
            end
        end
    endtask

    initial begin
        nrst = 1'b1;
        listen = 1'b0;
        resync = 1'b0;
        resync2 = 1'b0;
        adc_d = 8'd128;
        threshold = 8'd40;
        #2;
        test_reset();
        test_square();
        test_constant();
        test_threshold();
        test_listen();
        test_param();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hf_mod_detect_ssp.md
# hf_mod_detect_ssp

Parametrised ISO14443 reader-side receive path for the HF FPGA image: it filters the raw ADC stream, decides per subcarrier window whether a tag load-modulation is present, and serialises those decisions to the ARM over SSP. It generalises the fixed fc/16, 8-bit-frame detector to configurable subcarrier period, frame length, ADC width and runtime threshold. It also adds phase resync and a per-frame modulation count.

## Interface
- `ADC_W`, 8, ADC sample width.
- `SUB_LOG2`, 4, log2 of carrier cycles per subcarrier window (min 2; 4 = fc/16).
- `FRAME_LOG2`, 3, log2 of bits per SSP frame (3 = 8 bits).
- `RESET_PHASE`, 3, window phase (0..2^SUB_LOG2-1) at which the detector decides and clears.

Ports:
- `osc_clk`, in, 1, carrier clock (13.56 MHz); all logic on rising edge.
- `nrst`, in, 1, asynchronous active-low reset.
- `adc_d`, in, ADC_W, unsigned ADC sample.
- `threshold`, in, ADC_W, unsigned edge threshold; sampled every cycle.
- `listen`, in, 1, 1 = reader-listen mode; 0 = detector idle, zeros sent.
- `resync`, in, 1, synchronous; forces phase counter to 0.
- `curbit`, out, 1, latest window decision.
- `ssp_clk`, out, 1, SSP clock to ARM.
- `ssp_frame`, out, 1, SSP frame strobe.
- `ssp_din`, out, 1, SSP data to ARM.
- `mod_count`, out, FRAME_LOG2+1, count of 1-bits sent in the last completed frame.
- `frame_done`, out, 1, one-cycle pulse when `mod_count` updates.

## Operation
- Phase counter `cnt`, width `SUB_LOG2+FRAME_LOG2`, increments every cycle and wraps from all-ones to 0.
- `resync`=1: `cnt`<=0; it overrides the increment.
- `win` = `cnt[SUB_LOG2-1:0]`. `bitidx` = `cnt[top FRAME_LOG2 bits]`.
- Delay line `p1`..`p4`: `p1`<=`adc_d`, `p2`<=`p1`, `p3`<=`p2`, `p4`<=`p3` every cycle.
- Filter is combinational: `f = (2*p4 + p3) - (2*adc_d + p1)`.
  - Operands are zero-extended.
  - `f` is signed, ADC_W+3 bits, with no overflow possible.
- Edge tracker registers `fall_max`, `rise_min`, signed ADC_W+3 bits.
  - When `win`==RESET_PHASE:
    - `curbit` <= `listen` & (`fall_max` > thr) & (`rise_min` < -thr), where thr = zero-extended `threshold`.
    - `fall_max` <= 0 and `rise_min` <= 0.
  - Otherwise:
    - If `f`>0 and `f`>`fall_max`: `fall_max`<=`f`.
    - Else if `f`<`rise_min`: `rise_min`<=`f`.
    - `f`==0 changes nothing.
  - `listen`=0: both trackers are held at 0 and `curbit` is 0 from the next decision point on.
- SSP bit stage, on the edge where `win`==0:
  - `ssp_din` <= `listen` & `curbit`.
  - If `bitidx`==0: `acc` <= that same bit, `mod_count` <= `acc`, and `frame_done` <= 1.
  - Otherwise `acc` <= `acc` + bit.
- `frame_done` is 0 on all other cycles.
- `ssp_clk`:
  - Set to 1 on the edge where `win`==0.
  - Set to 0 on the edge where `win`==2^(SUB_LOG2-1).
  - Holds otherwise.
- `ssp_frame`:
  - Set to 1 on the edge where `cnt`==2^(SUB_LOG2-1)-1.
  - Set to 0 on the edge where `cnt`==2^SUB_LOG2+2^(SUB_LOG2-1)-1.
  - For the defaults these are 7 and 23.
- Bits go out MSB-first in time order; `bitidx` 0 is the first bit of a frame.

## Timing
- All compare values refer to `cnt` before the edge.
- Reset values: `cnt`, `p1`..`p4`, `fall_max`, `rise_min`, `acc`, `curbit`, `ssp_clk`, `ssp_frame`, `ssp_din`, `mod_count`, `frame_done` are all 0.
- The first frame after reset reports `mod_count`=0.
- Filter latency: `adc_d` affects `f` in the same cycle and the trackers on the next edge.
- Decision to wire latency: `curbit` updates on the RESET_PHASE edge. It reaches `ssp_din` on the next `win`==0 edge, 2^SUB_LOG2-RESET_PHASE cycles later.
- `mod_count` covers the 2^FRAME_LOG2 bits ending with the bit sent just before `frame_done`.
- `resync` mid-frame:
  - Counter restarts at 0; the next edge is a `win`==0 edge.
  - A partial frame is reported as a completed frame at that boundary.
  - Trackers are not cleared by `resync`.
- `resync` and counter wrap in the same cycle: behaviour is identical, `cnt`<=0.
- `nrst` assertion mid-frame: all state clears immediately (asynchronous). After release, operation restarts from `cnt`=0.
- `threshold` change takes effect at the next decision point. Decisions use the value present on that edge.

## Test plan
- Reset: hold `nrst`=0 with random inputs, then release. All outputs stay 0 through the first 2^(SUB_LOG2+FRAME_LOG2) cycles, except `ssp_clk` and `ssp_frame` toggling at the specified counts.
- Square-wave modulation: `listen`=1, `threshold`=40, `adc_d` alternating 100/200 every 8 cycles (defaults). Required: every decision is 1, `ssp_din`=1 for all 8 bits, `mod_count`=8.
- Constant carrier: `adc_d`=128 with `listen`=1. Required: `ssp_din`=0 and `mod_count`=0.
- Threshold boundary: edges producing `fall_max`=40 and `rise_min`=-40 give decision 0. With `threshold`=39 they give decision 1.
- `listen` toggle: modulated input with `listen` dropped mid-frame. Required: `ssp_din`=0 from the next `win`==0 edge, and the reported `mod_count` equals the 1-bits sent before the drop.
- Parametrised run at `SUB_LOG2`=3, `FRAME_LOG2`=4:
  - `ssp_clk` period is 8 cycles.
  - `ssp_frame` rises at `cnt`=3 and falls at `cnt`=11.
  - `frame_done` period is 128 cycles.
  - `resync` at `cnt`=50 gives the next `frame_done` one cycle later.
